// File: rtl/qracc_bus_master.sv
// qracc_bus_master: turns one command into single-word bus writes (from a write stream) or reads (to a read stream).
// Optional read-response timeout with sticky err_o: define QRACC_BUS_MASTER_TIMEOUT_EN.
module qracc_bus_master #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              cmd_incr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic              bus_wen_o,
  output logic              bus_ren_o,
  input  logic              bus_gnt_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_rvalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              incr_q, incr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] addr_next_c;
  logic              wr_room_c;
  logic              wr_hs_c;
  logic              wr_gnt_c;

`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
  localparam int unsigned TMO_W = 8;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign addr_next_c = incr_q ? addr_q + ADDR_W'(ADDR_STEP) : addr_q;

  // Room for another stream word: slot free (or freeing now) and a beat not yet loaded remains.
  assign wr_room_c  = (!wen_q || bus_gnt_i) &&
                      (wen_q ? (rem_q > LEN_W'(1)) : (rem_q != '0));
  assign wr_ready_o = (state_q == WR) && wr_room_c;
  assign wr_hs_c    = wr_ready_o && wr_valid_i;
  assign wr_gnt_c   = (state_q == WR) && wen_q && bus_gnt_i;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign bus_ren_o   = (state_q == RD_REQ);
  assign bus_wen_o   = wen_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign rd_data_o   = rdata_q;
  assign rd_valid_o  = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      incr_q   <= 1'b0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
      err_q    <= 1'b0;
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      incr_q   <= incr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
      err_q    <= err_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    incr_d   = incr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
    err_d    = err_q;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          rem_d  = cmd_len_i;
          incr_d = cmd_incr_i;
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          if (cmd_len_i == '0)  state_d = DONE;
          else if (cmd_write_i) state_d = WR;
          else                  state_d = RD_REQ;
        end
      end
      WR: begin
        if (wr_hs_c) begin
          wdata_d = wr_data_i;
          wen_d   = 1'b1;
        end else if (wr_gnt_c) begin
          wen_d   = 1'b0;
        end
        if (wr_gnt_c) begin
          rem_d  = rem_q - LEN_W'(1);
          addr_d = addr_next_c;
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      RD_REQ: begin
        if (bus_gnt_i) begin
          state_d = RD_WAIT;
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      RD_WAIT: begin
        if (bus_rvalid_i) begin
          rdata_d  = bus_rdata_i;
          rvalid_d = 1'b1;
          state_d  = RD_OUT;
        end
`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
        // 255th silent cycle: deliver a zero word and flag the error.
        else if (tmo_q == TMO_W'(254)) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          rvalid_d = 1'b1;
          state_d  = RD_OUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      RD_OUT: begin
        if (rd_ready_i) begin
          rvalid_d = 1'b0;
          rem_d    = rem_q - LEN_W'(1);
          addr_d   = addr_next_c;
          state_d  = (rem_q == LEN_W'(1)) ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_qracc_bus_master.sv
// Directed bench for qracc_bus_master: bus writes and read data are checked against scoreboard queues.
module tb_qracc_bus_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_incr_i;
  logic [31:0] cmd_addr_i;
  logic [15:0] cmd_len_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o, rd_ready_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        bus_wen_o, bus_ren_o, bus_gnt_i, bus_rvalid_i;
  logic        busy_o, done_o, err_o;

  qracc_bus_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_incr_i(cmd_incr_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wen_o(bus_wen_o),
    .bus_ren_o(bus_ren_o), .bus_gnt_i(bus_gnt_i), .bus_rdata_i(bus_rdata_i),
    .bus_rvalid_i(bus_rvalid_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {logic [31:0] a; logic [31:0] d;} wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_ra[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          failures = 0;
  int          busy_cnt = 0, done_cnt = 0, wen_cnt = 0;
  logic        mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations on bus write grants, read grants and read-stream handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t w;
      logic [31:0] v;
      check("wen_ren_exclusive", 64'(bus_wen_o & bus_ren_o), 64'd0);
      if (bus_wen_o && bus_gnt_i) begin
        check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(bus_addr_o), 64'(w.a));
          check("wr_data", 64'(bus_wdata_o), 64'(w.d));
        end
      end
      if (bus_ren_o && bus_gnt_i) begin
        check("rd_req_expected", 64'(exp_ra.size() != 0), 64'd1);
        if (exp_ra.size() != 0) begin
          v = exp_ra.pop_front();
          check("rd_addr", 64'(bus_addr_o), 64'(v));
        end
      end
      if (rd_valid_o && rd_ready_i) begin
        check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) begin
          v = exp_rd.pop_front();
          check("rd_data", 64'(rd_data_o), 64'(v));
        end
      end
      if (busy_o)    busy_cnt++;
      if (done_o)    done_cnt++;
      if (bus_wen_o) wen_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [15:0] l, input logic inc);
    cmd_valid_i = 1'b1; cmd_write_i = w; cmd_addr_i = a; cmd_len_i = l; cmd_incr_i = inc;
    @(negedge clk);
    for (int i = 0; i < 50 && !cmd_ready_o; i++) @(negedge clk);
    check("cmd_ready", 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    wr_valid_i = 1'b1; wr_data_i = d;
    @(negedge clk);
    for (int i = 0; i < 50 && !wr_ready_o; i++) @(negedge clk);
    check("wr_ready_seen", 64'(wr_ready_o), 64'd1);
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    @(negedge clk);
    for (int i = 0; i < 400 && !done_o; i++) @(negedge clk);
    check("done_seen", 64'(done_o), 64'd1);
    tick();
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'd0);
    check("idle_ready", 64'(cmd_ready_o), 64'd1);
    tick();
  endtask

  task automatic read_word(input logic [31:0] d, input bit stall);
    @(negedge clk);
    for (int i = 0; i < 50 && !bus_ren_o; i++) @(negedge clk);
    check("ren_seen", 64'(bus_ren_o), 64'd1);
    tick();
    tick();
    bus_rvalid_i = 1'b1; bus_rdata_i = d;
    tick();
    bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    if (stall) begin
      // Stray response while the word is held must not disturb it.
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        check("rd_hold_valid", 64'(rd_valid_o), 64'd1);
        check("rd_hold_data", 64'(rd_data_o), 64'(d));
        check("rd_hold_no_ren", 64'(bus_ren_o), 64'd0);
        tick();
        bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      end
    end
    rd_ready_i = 1'b1;
    @(negedge clk);
    check("rd_valid_at_hs", 64'(rd_valid_o), 64'd1);
    tick();
    rd_ready_i = 1'b0;
  endtask

  initial begin
    int b0, d0, w0;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_incr_i = 1'b0;
    wr_data_i = '0; wr_valid_i = 1'b0; rd_ready_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rdata_i = '0; bus_rvalid_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_wen", 64'(bus_wen_o), 64'd0);
    check("rst_ren", 64'(bus_ren_o), 64'd0);
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("rst_addr", 64'(bus_addr_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // Write burst at full throughput.
    bus_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) exp_wr.push_back({32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});
    b0 = busy_cnt; d0 = done_cnt; w0 = wen_cnt;
    send_cmd(1'b1, 32'h100, 16'd4, 1'b1);
    for (int i = 0; i < 4; i++) feed(32'hA0 + 32'(i));
    wait_done();
    check("wr1_busy_cycles", 64'(busy_cnt - b0), 64'd6);
    check("wr1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("wr1_wen_cycles", 64'(wen_cnt - w0), 64'd4);
    check("wr1_sb_empty", 64'(exp_wr.size()), 64'd0);

    // Same write with a 3-cycle grant stall on beat 2.
    for (int i = 0; i < 4; i++) exp_wr.push_back({32'h100 + 32'(4 * i), 32'hA0 + 32'(i)});
    w0 = wen_cnt;
    send_cmd(1'b1, 32'h100, 16'd4, 1'b1);
    feed(32'hA0);
    feed(32'hA1);
    bus_gnt_i = 1'b0; wr_valid_i = 1'b1; wr_data_i = 32'hA2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_addr", 64'(bus_addr_o), 64'h104);
      check("stall_data", 64'(bus_wdata_o), 64'hA1);
      check("stall_wen", 64'(bus_wen_o), 64'd1);
      check("stall_wr_ready", 64'(wr_ready_o), 64'd0);
      tick();
    end
    bus_gnt_i = 1'b1;
    @(negedge clk);
    check("stall4_addr", 64'(bus_addr_o), 64'h104);
    check("stall4_data", 64'(bus_wdata_o), 64'hA1);
    check("stall4_wr_ready", 64'(wr_ready_o), 64'd1);
    tick();
    wr_valid_i = 1'b0;
    feed(32'hA3);
    wait_done();
    check("wr2_wen_cycles", 64'(wen_cnt - w0), 64'd7);
    check("wr2_sb_empty", 64'(exp_wr.size()), 64'd0);

    // Fixed-address read burst with responder latency 2 and a held first word.
    for (int i = 0; i < 3; i++) begin
      exp_ra.push_back(32'h10);
      exp_rd.push_back(32'hD0 + 32'(i));
    end
    send_cmd(1'b0, 32'h10, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) read_word(32'hD0 + 32'(i), i == 0);
    wait_done();
    check("rd_ra_empty", 64'(exp_ra.size()), 64'd0);
    check("rd_sb_empty", 64'(exp_rd.size()), 64'd0);
    check("rd_err", 64'(err_o), 64'd0);

`ifdef QRACC_BUS_MASTER_TIMEOUT_EN
    // Responder never answers: zero word, sticky error, burst completes.
    exp_ra.push_back(32'h20);
    exp_rd.push_back(32'h0);
    send_cmd(1'b0, 32'h20, 16'd1, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 400 && !rd_valid_o; i++) @(negedge clk);
    check("tmo_rd_valid", 64'(rd_valid_o), 64'd1);
    check("tmo_err", 64'(err_o), 64'd1);
    check("tmo_data", 64'(rd_data_o), 64'd0);
    tick();
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
    wait_done();
    check("tmo_err_sticky", 64'(err_o), 64'd1);
`endif

    // Zero-length command.
    d0 = done_cnt;
    send_cmd(1'b1, 32'h200, 16'd0, 1'b1);
    @(negedge clk);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_wen", 64'(bus_wen_o), 64'd0);
    check("len0_ren", 64'(bus_ren_o), 64'd0);
    check("len0_err_cleared", 64'(err_o), 64'd0);
    tick();
    @(negedge clk);
    check("len0_done_low", 64'(done_o), 64'd0);
    check("len0_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("len0_done_pulses", 64'(done_cnt - d0), 64'd1);
    tick();

    // Reset during beat 3 of an 8-beat write.
    for (int i = 0; i < 3; i++) exp_wr.push_back({32'h300 + 32'(4 * i), 32'hB0 + 32'(i)});
    send_cmd(1'b1, 32'h300, 16'd8, 1'b1);
    for (int i = 0; i < 3; i++) feed(32'hB0 + 32'(i));
    d0 = done_cnt;
    wr_valid_i = 1'b1; wr_data_i = 32'hB3;
    rst = 1'b1;
    tick();
    rst = 1'b0; wr_valid_i = 1'b0;
    @(negedge clk);
    check("rst_mid_wen", 64'(bus_wen_o), 64'd0);
    check("rst_mid_ren", 64'(bus_ren_o), 64'd0);
    check("rst_mid_addr", 64'(bus_addr_o), 64'd0);
    check("rst_mid_wdata", 64'(bus_wdata_o), 64'd0);
    check("rst_mid_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    repeat (3) tick();
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_mid_sb_empty", 64'(exp_wr.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qracc_bus_master.md
# qracc_bus_master

Bus initiator that drives the accelerator's memory-mapped request/response interface from a simple command port. It turns one command (base address, word count, direction) into a burst of single-word bus writes fed from a write stream, or single-word bus reads returned on a read stream. It sits between a host-side controller or testbench sequencer and the accelerator top. It is the standard way to:
- load CSRs, scaler parameters, weights and activations;
- read back activation-buffer results.

## Interface
Parameters:
- `DATA_W`, 32, bus data width
- `ADDR_W`, 32, bus address width
- `LEN_W`, 16, width of the command word count
- `ADDR_STEP`, 4, address increment per beat in incrementing mode

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid_i` in 1: command offered.
- `cmd_ready_o` out 1: command accepted when both are high.
- `cmd_write_i` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr_i` in `ADDR_W`: first beat address.
- `cmd_len_i` in `LEN_W`: number of words.
- `cmd_incr_i` in 1: 1 = add `ADDR_STEP` per beat; 0 = fixed address (FIFO-style ports such as the weight stream).
- `wr_data_i` in `DATA_W`: write stream data.
- `wr_valid_i` in 1: write stream valid.
- `wr_ready_o` out 1: write stream ready.
- `rd_data_o` out `DATA_W`: read stream data.
- `rd_valid_o` out 1: read stream valid.
- `rd_ready_i` in 1: read stream ready.
- `bus_addr_o` out `ADDR_W`: bus request address (maps to `bus_req_t.addr`).
- `bus_wdata_o` out `DATA_W`: bus write data (maps to `bus_req_t.data_in`).
- `bus_wen_o` out 1: bus write request.
- `bus_ren_o` out 1: bus read request.
- `bus_gnt_i` in 1: responder accepts the current request this cycle.
- `bus_rdata_i` in `DATA_W`: read response data (maps to `bus_resp_t.data_out`).
- `bus_rvalid_i` in 1: read response valid.
- `busy_o` out 1: high from command accept until the done cycle inclusive.
- `done_o` out 1: one-cycle pulse at burst end.
- `err_o` out 1: sticky read-timeout flag.

## Operation
- State machine states: IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, DONE.
- **IDLE.**
  - `cmd_ready_o`=1.
  - On accept, latch address, remaining count and mode.
  - If `cmd_len_i`=0, go to DONE.
  - Otherwise go to WR or RD_REQ according to `cmd_write_i`.
- **WR.**
  - `wr_ready_o` = (`bus_wen_o`=0 or `bus_gnt_i`=1) and remaining>0.
  - A stream handshake registers `bus_wdata_o`, `bus_addr_o` and `bus_wen_o`=1.
  - `bus_wen_o` holds with stable addr/data until `bus_gnt_i`.
  - Each grant decrements the remaining count and steps the address if incrementing.
  - Go to DONE on the grant of the last beat.
- **RD_REQ.**
  - Drive `bus_ren_o`=1 with the current address until `bus_gnt_i`, then go to RD_WAIT.
- **RD_WAIT.**
  - On `bus_rvalid_i`, register `bus_rdata_i` into `rd_data_o`, set `rd_valid_o`, go to RD_OUT.
- **RD_OUT.**
  - Hold `rd_data_o`/`rd_valid_o` until `rd_ready_i`.
  - Then decrement the count and step the address.
  - Go to RD_REQ if words remain, else DONE.
- **DONE.**
  - `done_o`=1 for one cycle, then return to IDLE.
- Only one read is outstanding at a time.
- `bus_rvalid_i` is ignored outside RD_WAIT.
- `bus_wen_o` and `bus_ren_o` are never high simultaneously.
- Address arithmetic is modulo 2^`ADDR_W` and wraps silently.
- The count is unsigned `LEN_W` bits, so the maximum burst is 2^`LEN_W`-1 words.

## Timing
- **Reset values.** All outputs are 0 except `cmd_ready_o`=1 (IDLE). The state returns to IDLE.
- **Reset mid-burst.** The burst is aborted the cycle after `rst` is sampled high, with no done pulse. Any in-flight `bus_rvalid_i` is dropped.
- **Write latency.** Stream handshake at cycle t gives `bus_wen_o` at t+1.
- **Write throughput.** One word per cycle with `bus_gnt_i` tied high.
- **Read latency.** `bus_ren_o` is asserted the cycle after accept/RD_REQ entry. Response at cycle r gives `rd_valid_o` at r+1.
- **Done timing.** `done_o` comes 1 cycle after the last grant (write) or the last `rd_ready_i` handshake (read).
- **Command overlap.** A new command can be accepted the cycle after `done_o`. `cmd_valid_i` during busy is held off, not dropped.

## Configuration
- `QRACC_BUS_MASTER_TIMEOUT_EN` defined:
  - An 8-bit counter runs in RD_WAIT.
  - After 255 cycles without `bus_rvalid_i`:
    - set sticky `err_o`;
    - present `rd_data_o`=0 with `rd_valid_o`=1;
    - continue the burst.
  - `err_o` clears only on `rst` or on the next command accept.
- Not defined:
  - RD_WAIT waits indefinitely.
  - `err_o` is tied 0.

## Test plan
- Write burst, addr 0x100, len 4, incr, `bus_gnt_i`=1, data 0xA0..0xA3 → 4 consecutive `bus_wen_o` cycles at 0x100/0x104/0x108/0x10C, then `done_o` pulse; `busy_o` high for 6 cycles.
- Same write with `bus_gnt_i` low for 3 cycles on beat 2 → addr 0x104/data 0xA1 held stable 4 cycles; `wr_ready_o` low meanwhile; no beat lost or duplicated.
- Read burst, addr 0x10, len 3, fixed address, responder latency 2, `rd_ready_i` low 2 cycles on word 1 → 3 `bus_ren_o` grants all at 0x10; `rd_data_o` matches responses in order; next `bus_ren_o` only after each handshake.
- `cmd_len_i`=0 → `done_o` one cycle after accept; no bus activity.
- `rst` asserted during beat 3 of an 8-beat write → next cycle all bus outputs 0, `cmd_ready_o`=1, no `done_o`.
- With `QRACC_BUS_MASTER_TIMEOUT_EN`, responder never answers → `err_o`=1 after 255 RD_WAIT cycles, `rd_data_o`=0 delivered, `done_o` follows.
